// File: rtl/mii_rx_axis.sv
// MII nibble receiver to AXI-Stream byte stream with FCS stripping, CRC-32 check,
// runt filtering and single-entry output register with overflow marking.
module mii_rx_axis #(
  parameter int RUNT_BYTES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] mii_rxd,
  input  logic       mii_rx_dv,
  input  logic       mii_rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       busy,
  output logic       crc_error,
  output logic       runt,
  output logic       overflow
);

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t           state, state_nxt;
  logic             dv_q;
  logic             phase;
  logic [3:0]       low_nib;
  logic [15:0]      nib_cnt, byte_cnt;
  logic [31:0]      crc;
  logic             er_seen;
  logic [3:0][7:0]  dly;
  logic [7:0]       pend;
  logic             pend_vld;

  logic             sfd, byte_done, push, push_last, push_user;
  logic             runt_det, crc_bad_end, ovf, out_free;
  logic [7:0]       byte_new;
  logic [31:0]      crc_next;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign byte_new = {mii_rxd, low_nib};
  assign crc_next = crc_byte(crc, byte_new);
  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign busy     = (state != IDLE) || m_axis_tvalid;

  always_comb begin
    state_nxt   = state;
    sfd         = 1'b0;
    byte_done   = 1'b0;
    push        = 1'b0;
    push_last   = 1'b0;
    push_user   = 1'b0;
    runt_det    = 1'b0;
    crc_bad_end = 1'b0;
    ovf         = 1'b0;
    case (state)
      IDLE: begin
        // only a fresh rising edge starts a frame, so a frame cut by reset is not re-entered
        if (mii_rx_dv && !dv_q)
          state_nxt = (mii_rxd == 4'h5) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!mii_rx_dv)
          state_nxt = IDLE;
        else if (mii_rx_er || (mii_rxd != 4'h5 && mii_rxd != 4'hD))
          state_nxt = DROP;
        else if (mii_rxd == 4'hD) begin
          state_nxt = DATA;
          sfd       = 1'b1;
        end
      end
      DATA: begin
        if (!mii_rx_dv) begin
          state_nxt = IDLE;
          if (byte_cnt < 16'(RUNT_BYTES))
            runt_det = 1'b1;
          else begin
            push        = 1'b1;
            push_last   = 1'b1;
            crc_bad_end = (crc != CRC_RESIDUE);
            push_user   = crc_bad_end || er_seen || phase;
          end
        end else if (phase) begin
          byte_done = 1'b1;
          push      = pend_vld;
        end
      end
      DROP: begin
        if (!mii_rx_dv) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (push && !out_free) begin
      ovf       = 1'b1;
      state_nxt = push_last ? IDLE : DROP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      dv_q          <= 1'b1;
      phase         <= 1'b0;
      low_nib       <= 4'h0;
      nib_cnt       <= 16'h0;
      byte_cnt      <= 16'h0;
      crc           <= 32'hFFFFFFFF;
      er_seen       <= 1'b0;
      dly           <= '0;
      pend          <= 8'h00;
      pend_vld      <= 1'b0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      crc_error     <= 1'b0;
      runt          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state     <= state_nxt;
      dv_q      <= mii_rx_dv;
      crc_error <= crc_bad_end && !ovf;
      runt      <= runt_det;
      overflow  <= ovf;

      if (sfd) begin
        crc      <= 32'hFFFFFFFF;
        byte_cnt <= 16'h0;
        nib_cnt  <= 16'h0;
        phase    <= 1'b0;
        er_seen  <= 1'b0;
        pend_vld <= 1'b0;
      end

      if (state == DATA && mii_rx_dv) begin
        phase   <= !phase;
        er_seen <= er_seen || mii_rx_er;
        if (nib_cnt != 16'hFFFF) nib_cnt <= nib_cnt + 16'h1;
        if (!phase) low_nib <= mii_rxd;
      end

      // the last four bytes are held back so the FCS never reaches the output
      if (byte_done) begin
        crc <= crc_next;
        dly <= {dly[2:0], byte_new};
        if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'h1;
        if (byte_cnt >= 16'd4) begin
          pend     <= dly[3];
          pend_vld <= 1'b1;
        end
      end

      if (state == DATA && state_nxt != DATA) pend_vld <= 1'b0;

      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (push) begin
        if (out_free) begin
          m_axis_tdata  <= pend;
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= push_last;
          m_axis_tuser  <= push_user;
        end else begin
          // collision: close the held beat as a bad frame end
          m_axis_tlast <= 1'b1;
          m_axis_tuser <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mii_rx_axis.sv
// Bench for mii_rx_axis: table-driven frames, random frames against a frame-level model,
// and hand sequences for overflow and mid-frame reset.
module tb_mii_rx_axis;
  localparam int RUNT = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] mii_rxd = 4'h0;
  logic       mii_rx_dv = 1'b0;
  logic       mii_rx_er = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic       busy, crc_error, runt, overflow;

  mii_rx_axis #(.RUNT_BYTES(RUNT)) dut (
    .clk(clk), .reset(reset), .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .busy(busy),
    .crc_error(crc_error), .runt(runt), .overflow(overflow));

  always #5 clk = !clk;

  int total = 0, bad = 0;
  logic [7:0] frm[$];
  logic [9:0] beats[$];   // {tlast, tuser, tdata}
  int n_crc, n_crc_co, n_runt, n_ovf;

  typedef struct {
    string name; int len; bit corrupt; int er_idx; bit odd; bit pre_bad;
    int exp_beats; bit exp_tuser; int exp_crc; int exp_runt;
  } vec_t;
  vec_t tbl[$];

  always @(negedge clk) begin
    if (reset) begin
      if (m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
      if (crc_error) begin
        n_crc++;
        if (m_axis_tvalid && m_axis_tlast) n_crc_co++;
      end
      if (runt) n_runt++;
      if (overflow) n_ovf++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc32_of(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic make_frame(input int len, input bit corrupt);
    logic [31:0] fcs;
    frm.delete();
    if (len < 4) begin
      for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
    end else begin
      for (int i = 0; i < len - 4; i++) frm.push_back(8'($urandom));
      fcs = crc32_of(len - 4);
      for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
      if (corrupt) frm[len-4] = frm[len-4] ^ 8'h01;
    end
  endtask

  function automatic bit fcs_ok();
    int n = frm.size();
    if (n < 4) return 1'b0;
    return crc32_of(n - 4) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
  endfunction

  task automatic drive(input logic dv, input logic [3:0] d, input logic er);
    @(posedge clk); #1;
    mii_rx_dv = dv; mii_rxd = d; mii_rx_er = er;
  endtask

  task automatic send_frame(input int er_idx, input bit odd, input bit pre_bad);
    for (int i = 0; i < 7; i++) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, pre_bad ? 4'h3 : 4'hD, 1'b0);
    for (int i = 0; i < frm.size(); i++) begin
      drive(1'b1, frm[i][3:0], i == er_idx);
      drive(1'b1, frm[i][7:4], 1'b0);
    end
    if (odd) drive(1'b1, 4'($urandom), 1'b0);
    drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic clear_obs();
    beats.delete();
    n_crc = 0; n_crc_co = 0; n_runt = 0; n_ovf = 0;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy && !m_axis_tvalid) done = 1'b1;
    end
    chk({tag, ":drain"}, 32'(done), 1);
  endtask

  task automatic check_frame(input string tag, input int exp_beats, input bit exp_tuser,
                             input int exp_crc, input int exp_runt);
    int mism = 0, nlast = 0;
    for (int i = 0; i < beats.size(); i++) begin
      if (i >= frm.size() || beats[i][7:0] != frm[i]) mism++;
      if (beats[i][9]) nlast++;
    end
    chk({tag, ":beats"}, 32'(beats.size()), 32'(exp_beats));
    chk({tag, ":data"}, 32'(mism), 0);
    if (exp_beats > 0) begin
      chk({tag, ":nlast"}, 32'(nlast), 1);
      chk({tag, ":last_is_end"}, 32'(beats[beats.size()-1][9]), 1);
      chk({tag, ":tuser"}, 32'(beats[beats.size()-1][8]), 32'(exp_tuser));
    end else
      chk({tag, ":nlast"}, 32'(nlast), 0);
    chk({tag, ":crc_pulse"}, 32'(n_crc), 32'(exp_crc));
    chk({tag, ":crc_coincident"}, 32'(n_crc_co), 32'(exp_crc));
    chk({tag, ":runt_pulse"}, 32'(n_runt), 32'(exp_runt));
    chk({tag, ":ovf_pulse"}, 32'(n_ovf), 0);
    chk({tag, ":busy"}, 32'(busy), 0);
  endtask

  task automatic run_vec(input vec_t v);
    clear_obs();
    make_frame(v.len, v.corrupt);
    send_frame(v.er_idx, v.odd, v.pre_bad);
    wait_drain(v.name);
    check_frame(v.name, v.exp_beats, v.exp_tuser, v.exp_crc, v.exp_runt);
  endtask

  initial begin
    m_axis_tready = 1'b1;
    tbl = '{
      '{"good64",   64, 0, -1, 0, 0, 60, 0, 0, 0},
      '{"badfcs64", 64, 1, -1, 0, 0, 60, 1, 1, 0},
      '{"rxer64",   64, 0, 20, 0, 0, 60, 1, 0, 0},
      '{"odd64",    64, 0, -1, 1, 0, 60, 1, 0, 0},
      '{"runt3",     3, 0, -1, 0, 0,  0, 0, 0, 1},
      '{"runt4",     4, 0, -1, 0, 0,  0, 0, 0, 1},
      '{"min5",      5, 0, -1, 0, 0,  1, 0, 0, 0},
      '{"badsfd",   64, 0, -1, 0, 1,  0, 0, 0, 0}
    };

    // reset state
    repeat (3) @(negedge clk);
    chk("rst:tvalid", 32'(m_axis_tvalid), 0);
    chk("rst:tlast", 32'(m_axis_tlast), 0);
    chk("rst:tuser", 32'(m_axis_tuser), 0);
    chk("rst:tdata", 32'(m_axis_tdata), 0);
    chk("rst:busy", 32'(busy), 0);
    chk("rst:pulses", 32'({crc_error, runt, overflow}), 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (4) @(posedge clk);

    foreach (tbl[i]) run_vec(tbl[i]);

    // random frames against the frame-level model
    for (int k = 0; k < 12; k++) begin
      int len, er_idx;
      bit corrupt, odd, is_runt, ok;
      len     = $urandom_range(1, 80);
      corrupt = ($urandom_range(0, 3) == 0);
      er_idx  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
      odd     = ($urandom_range(0, 4) == 0);
      clear_obs();
      make_frame(len, corrupt);
      is_runt = (len < RUNT);
      ok      = fcs_ok();
      send_frame(er_idx, odd, 1'b0);
      wait_drain($sformatf("rnd%0d", k));
      check_frame($sformatf("rnd%0d", k), is_runt ? 0 : len - 4,
                  !ok || (er_idx >= 0) || odd, (!is_runt && !ok) ? 1 : 0, is_runt ? 1 : 0);
    end

    // back-pressure collision mid-frame
    begin
      int mism = 0;
      clear_obs();
      make_frame(64, 1'b0);
      fork
        send_frame(-1, 1'b0, 1'b0);
        begin
          repeat (40) @(posedge clk);
          #1 m_axis_tready = 1'b0;
          repeat (4) @(posedge clk);
          #1 m_axis_tready = 1'b1;
        end
      join
      wait_drain("ovf");
      for (int i = 0; i < beats.size(); i++)
        if (beats[i][7:0] != frm[i] || (beats[i][9] && i != beats.size() - 1)) mism++;
      chk("ovf:pulse", 32'(n_ovf), 1);
      chk("ovf:truncated", 32'(beats.size() > 0 && beats.size() < 60), 1);
      chk("ovf:prefix", 32'(mism), 0);
      if (beats.size() > 0)
        chk("ovf:held_end", 32'(beats[beats.size()-1][9:8]), 3);
      chk("ovf:crc_pulse", 32'(n_crc), 0);
    end
    run_vec('{"after_ovf", 64, 0, -1, 0, 0, 60, 0, 0, 0});

    // reset asserted around byte 30
    begin
      int nlast = 0;
      clear_obs();
      make_frame(64, 1'b0);
      fork
        send_frame(-1, 1'b0, 1'b0);
        begin
          repeat (68) @(posedge clk);
          #1 reset = 1'b0;
          @(posedge clk); #1;
          chk("rstmid:tvalid", 32'(m_axis_tvalid), 0);
          @(posedge clk); #1 reset = 1'b1;
        end
      join
      wait_drain("rstmid");
      foreach (beats[i]) if (beats[i][9]) nlast++;
      chk("rstmid:nlast", 32'(nlast), 0);
      chk("rstmid:crc_pulse", 32'(n_crc), 0);
      chk("rstmid:runt_pulse", 32'(n_runt), 0);
    end
    run_vec('{"after_rst", 64, 0, -1, 0, 0, 60, 0, 0, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
